pulse_scheduler: RTL and testbench

- Programmable scheduler for the free-running cycle counter resource.
- Sequences a frame counter (start/stop FSM) and generates periodic control pulses on up to three compare channels, each firing every M_k enabled cycles within a frame of P cycles.
- Configured through a simple register-write port while idle.
- Sits between the control logic and the downstream blocks that consume o_control-type strobes.

---
 rtl/pulse_scheduler.sv | 126 ++++++++++++
 tb/tb_pulse_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_scheduler.sv
// Frame counter with start/stop FSM and N_CMP periodic compare channels, configured while idle.
// Optional one-shot frame mode is enabled by defining PULSE_SCHED_ONESHOT_EN (adds i_oneshot, o_done).
//
// state | meaning
// IDLE  | counters held at 0, config writes accepted
// RUN   | frame and channel counters advance on clk_enable
module pulse_scheduler #(
   parameter int N_BITS = 5,
   parameter int N_CMP  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_enable,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic              i_cfg_we,
   input  logic [2:0]        i_cfg_sel,
   input  logic [N_BITS-1:0] i_cfg_data,
`ifdef PULSE_SCHED_ONESHOT_EN
   input  logic              i_oneshot,
   output logic              o_done,
`endif
   output logic              o_cfg_ack,
   output logic              o_busy,
   output logic [N_BITS-1:0] o_count,
   output logic [N_CMP-1:0]  o_match,
   output logic              o_control,
   output logic              o_wrap
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state;
   logic [N_BITS-1:0]  p_reg;
   logic [N_BITS-1:0]  m_reg  [N_CMP];
   logic [N_BITS-1:0]  ch_cnt [N_CMP];
   logic [N_BITS-1:0]  count_inc;
   logic               wrap_hit;
   logic [N_CMP-1:0]   ch_hit;
   logic               cfg_valid;
`ifdef PULSE_SCHED_ONESHOT_EN
   logic               oneshot_q;
`endif

   // P=0 means a full 2^N_BITS frame: count_inc rolls over to 0 and matches p_reg.
   always_comb begin
      count_inc = o_count + N_BITS'(1);
      wrap_hit  = (count_inc == p_reg);
      cfg_valid = (i_cfg_sel == 3'd7) || (int'(i_cfg_sel) < N_CMP);
      ch_hit    = '0;
      for (int k = 0; k < N_CMP; k++) begin
         ch_hit[k] = (m_reg[k] != '0) && ((ch_cnt[k] + N_BITS'(1)) == m_reg[k]);
      end
   end

   assign o_busy = (state == RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         p_reg     <= '0;
         o_count   <= '0;
         o_cfg_ack <= 1'b0;
         o_match   <= '0;
         o_control <= 1'b0;
         o_wrap    <= 1'b0;
         for (int k = 0; k < N_CMP; k++) begin
            m_reg[k]  <= '0;
            ch_cnt[k] <= '0;
         end
`ifdef PULSE_SCHED_ONESHOT_EN
         oneshot_q <= 1'b0;
         o_done    <= 1'b0;
`endif
      end else begin
         o_cfg_ack <= 1'b0;
         o_match   <= '0;
         o_control <= 1'b0;
         o_wrap    <= 1'b0;
`ifdef PULSE_SCHED_ONESHOT_EN
         o_done    <= 1'b0;
`endif
         if (state == IDLE && i_cfg_we && cfg_valid) begin
            o_cfg_ack <= 1'b1;
            if (i_cfg_sel == 3'd7) p_reg <= i_cfg_data;
            for (int k = 0; k < N_CMP; k++) begin
               if (i_cfg_sel == 3'(k)) m_reg[k] <= i_cfg_data;
            end
         end
         case (state)
            IDLE: begin
               if (i_start && !i_stop) begin
                  state <= RUN;
`ifdef PULSE_SCHED_ONESHOT_EN
                  oneshot_q <= i_oneshot;
`endif
               end
            end
            RUN: begin
               if (i_stop) begin
                  state   <= IDLE;
                  o_count <= '0;
                  for (int k = 0; k < N_CMP; k++) ch_cnt[k] <= '0;
               end else if (clk_enable) begin
                  o_count   <= wrap_hit ? '0 : count_inc;
                  o_match   <= ch_hit;
                  o_control <= |ch_hit;
                  o_wrap    <= wrap_hit;
                  // Channels restart at every frame boundary to stay phase-aligned.
                  for (int k = 0; k < N_CMP; k++) begin
                     ch_cnt[k] <= (ch_hit[k] || wrap_hit) ? '0 : ch_cnt[k] + N_BITS'(1);
                  end
`ifdef PULSE_SCHED_ONESHOT_EN
                  if (oneshot_q && wrap_hit) begin
                     state  <= IDLE;
                     o_done <= 1'b1;
                  end
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Scoreboard bench for pulse_scheduler: a frame-number/modulo model pushes expected pulses per cycle.
// Define PULSE_SCHED_ONESHOT_EN to also exercise the one-shot frame mode.
module tb_pulse_scheduler;

   logic       clk = 1'b0;
   logic       reset, clk_enable, i_start, i_stop, i_cfg_we;
   logic [2:0] i_cfg_sel;
   logic [4:0] i_cfg_data;
   logic       o_cfg_ack, o_busy, o_control, o_wrap;
   logic [4:0] o_count;
   logic [2:0] o_match;
`ifdef PULSE_SCHED_ONESHOT_EN
   logic       i_oneshot, o_done;
`endif

   pulse_scheduler #(.N_BITS(5), .N_CMP(3)) dut (
      .clk(clk), .reset(reset), .clk_enable(clk_enable),
      .i_start(i_start), .i_stop(i_stop),
      .i_cfg_we(i_cfg_we), .i_cfg_sel(i_cfg_sel), .i_cfg_data(i_cfg_data),
`ifdef PULSE_SCHED_ONESHOT_EN
      .i_oneshot(i_oneshot), .o_done(o_done),
`endif
      .o_cfg_ack(o_cfg_ack), .o_busy(o_busy), .o_count(o_count),
      .o_match(o_match), .o_control(o_control), .o_wrap(o_wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] match;
      logic       wrap;
      logic [4:0] count;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // reference model state
   int   mp = 0;
   int   mm[3] = '{0, 0, 0};
   int   mcnt = 0;
   bit   m_oneshot = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive ncyc cycles in RUN; gate=1 gives a 1010... enable pattern.
   task automatic run_cycles(input int ncyc, input bit gate);
      exp_t e;
      exp_t g;
      int   peff, n;
      for (int i = 0; i < ncyc; i++) begin
         clk_enable = gate ? (i % 2 == 0) : 1'b1;
         peff = (mp == 0) ? 32 : mp;
         e.match = '0; e.wrap = 0; e.busy = 1; e.done = 0;
         if (clk_enable) begin
            n = mcnt + 1;
            for (int k = 0; k < 3; k++)
               if (mm[k] != 0 && (n % mm[k]) == 0) e.match[k] = 1'b1;
            e.wrap = (n == peff);
            mcnt   = n % peff;
            if (e.wrap && m_oneshot) begin
               e.busy = 0;
               e.done = 1;
            end
         end
         e.count = 5'(mcnt);
         sb.push_back(e);
         tick();
         g = sb.pop_front();
         checks += 4;
         if (o_match !== g.match) begin
            errors++; $display("FAIL match cyc %0d: got %b exp %b", i, o_match, g.match);
         end
         if (o_wrap !== g.wrap) begin
            errors++; $display("FAIL wrap cyc %0d: got %b exp %b", i, o_wrap, g.wrap);
         end
         if (o_control !== (|g.match)) begin
            errors++; $display("FAIL control cyc %0d: got %b exp %b", i, o_control, |g.match);
         end
         if (o_count !== g.count) begin
            errors++; $display("FAIL count cyc %0d: got %0d exp %0d", i, o_count, g.count);
         end
         checks++;
         if (o_busy !== g.busy) begin
            errors++; $display("FAIL busy cyc %0d: got %b exp %b", i, o_busy, g.busy);
         end
`ifdef PULSE_SCHED_ONESHOT_EN
         checks++;
         if (o_done !== g.done) begin
            errors++; $display("FAIL done cyc %0d: got %b exp %b", i, o_done, g.done);
         end
`endif
      end
      clk_enable = 1'b0;
   endtask

   task automatic cfg_write(input logic [2:0] sel, input logic [4:0] data, input bit exp_ack);
      i_cfg_we = 1'b1; i_cfg_sel = sel; i_cfg_data = data;
      tick();
      i_cfg_we = 1'b0;
      checks++;
      if (o_cfg_ack !== exp_ack) begin
         errors++; $display("FAIL cfg_ack sel %0d: got %b exp %b", sel, o_cfg_ack, exp_ack);
      end
      if (exp_ack) begin
         if (sel == 3'd7) mp = int'(data);
         else mm[sel] = int'(data);
      end
      tick();
      checks++;
      if (o_cfg_ack !== 1'b0) begin
         errors++; $display("FAIL cfg_ack_pulse sel %0d: got %b exp 0", sel, o_cfg_ack);
      end
   endtask

   task automatic do_start(input bit oneshot);
      i_start = 1'b1;
`ifdef PULSE_SCHED_ONESHOT_EN
      i_oneshot = oneshot;
      m_oneshot = oneshot;
`else
      m_oneshot = 0;
`endif
      tick();
      i_start = 1'b0;
      mcnt = 0;
      checks++;
      if (o_busy !== 1'b1 || o_count !== 5'd0) begin
         errors++; $display("FAIL start: got busy %b count %0d exp busy 1 count 0", o_busy, o_count);
      end
   endtask

   task automatic do_stop();
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      mcnt = 0;
      checks++;
      if (o_busy !== 1'b0 || o_count !== 5'd0) begin
         errors++; $display("FAIL stop: got busy %b count %0d exp busy 0 count 0", o_busy, o_count);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      mp = 0; mm = '{0, 0, 0}; mcnt = 0;
      checks++;
      if ({o_busy, o_count, o_match, o_control, o_wrap, o_cfg_ack} !== 12'd0) begin
         errors++;
         $display("FAIL reset: got busy %b count %0d match %b ctl %b wrap %b ack %b exp all 0",
                  o_busy, o_count, o_match, o_control, o_wrap, o_cfg_ack);
      end
   endtask

   task automatic test_frame32();
      cfg_write(3'd7, 5'd0, 1);
      cfg_write(3'd0, 5'd4, 1);
      cfg_write(3'd1, 5'd20, 1);
      cfg_write(3'd2, 5'd24, 1);
      do_start(0);
      run_cycles(64, 0);
      do_stop();
   endtask

   task automatic test_short_period();
      cfg_write(3'd7, 5'd10, 1);
      cfg_write(3'd0, 5'd3, 1);
      cfg_write(3'd1, 5'd0, 1);
      cfg_write(3'd2, 5'd0, 1);
      do_start(0);
      run_cycles(25, 0);
      do_stop();
   endtask

   task automatic test_gated();
      cfg_write(3'd7, 5'd0, 1);
      cfg_write(3'd0, 5'd4, 1);
      do_start(0);
      run_cycles(34, 1);
      do_stop();
   endtask

   task automatic test_cfg();
      cfg_write(3'd0, 5'd4, 1);
      do_start(0);
      cfg_write(3'd0, 5'd5, 0);
      mcnt = 0;
      do_stop();
      do_start(0);
      run_cycles(9, 0);
      do_stop();
      cfg_write(3'd0, 5'd5, 1);
      cfg_write(3'd5, 5'd9, 0);
      do_start(0);
      run_cycles(11, 0);
      do_stop();
   endtask

   task automatic test_stop_reset();
      i_start = 1'b1; i_stop = 1'b1;
      tick();
      i_start = 1'b0; i_stop = 1'b0;
      checks++;
      if (o_busy !== 1'b0) begin
         errors++; $display("FAIL start_and_stop: got busy %b exp 0", o_busy);
      end
      do_start(0);
      run_cycles(7, 0);
      do_stop();
      do_start(0);
      run_cycles(5, 0);
      test_reset();
      do_start(0);
      run_cycles(40, 0);
      do_stop();
   endtask

`ifdef PULSE_SCHED_ONESHOT_EN
   task automatic test_oneshot();
      cfg_write(3'd7, 5'd8, 1);
      cfg_write(3'd0, 5'd4, 1);
      do_start(1);
      run_cycles(8, 0);
      m_oneshot = 0;
      tick();
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_wrap !== 1'b0) begin
         errors++; $display("FAIL oneshot_end: got busy %b done %b wrap %b exp 0 0 0", o_busy, o_done, o_wrap);
      end
      i_oneshot = 1'b0;
   endtask
`endif

   initial begin
      reset = 1'b0; clk_enable = 1'b0; i_start = 1'b0; i_stop = 1'b0;
      i_cfg_we = 1'b0; i_cfg_sel = 3'd0; i_cfg_data = 5'd0;
`ifdef PULSE_SCHED_ONESHOT_EN
      i_oneshot = 1'b0;
`endif
      test_reset();
      test_frame32();
      test_short_period();
      test_gated();
      test_cfg();
      test_stop_reset();
`ifdef PULSE_SCHED_ONESHOT_EN
      test_oneshot();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
